// File: rtl/aui_pkg.sv
// Shared AUI definitions: default lane/egress widths and the gearbox FSM
// state type. Used by lane_gearbox and lane_fifo2.
package aui_pkg;

  localparam int LANE_WIDTH = 1360;
  localparam int OUT_WIDTH  = 136;
  localparam int BEATS      = LANE_WIDTH / OUT_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } gb_state_e;

endpackage

// File: rtl/lane_fifo2.sv
// Two-entry FIFO holding {sync, lane word}.
// Ports: clk, rst (async active-low), push/din write side, pop/dout read side
// (dout is the head entry), full/empty/count status (count in 0..2).
module lane_fifo2
  import aui_pkg::*;
#(
  parameter int W = aui_pkg::LANE_WIDTH + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [1:0][W-1:0] mem;
  logic              wr_ptr;
  logic              rd_ptr;

  // Storage carries no reset: it is only observed when count > 0.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/lane_gearbox.sv
// Lane gearbox: buffers up to two LANE_WIDTH lane words and serialises each
// into LANE_WIDTH/OUT_WIDTH beats, MSB beat first, over a valid/ready egress.
// Ports: clk, rst (async active-low); ingress i_valid/i_lane/i_sync/i_ready;
// egress o_valid/o_ready/o_data/o_sop/o_eow; sticky o_overflow (word dropped).
module lane_gearbox
  import aui_pkg::*;
#(
  parameter int LANE_WIDTH = aui_pkg::LANE_WIDTH,
  parameter int OUT_WIDTH  = aui_pkg::OUT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [LANE_WIDTH-1:0] i_lane,
  input  logic                  i_sync,
  output logic                  i_ready,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [OUT_WIDTH-1:0]  o_data,
  output logic                  o_sop,
  output logic                  o_eow,
  output logic                  o_overflow
);

  // LANE_WIDTH must be an integer multiple of OUT_WIDTH.
  localparam int BEATS = LANE_WIDTH / OUT_WIDTH;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  gb_state_e state, state_nxt;

  logic [BW-1:0]       beat;
  logic                push, pop, hs;
  logic                fifo_full, fifo_empty;
  logic [1:0]          fifo_count;
  logic [LANE_WIDTH:0] head;
  logic                head_sync;
  logic [BEATS-1:0][OUT_WIDTH-1:0] head_beats;
  logic [BW-1:0]       beat_idx;

  // i_ready comes straight from the registered fill level.
  assign i_ready = !fifo_full;
  assign push    = i_valid && i_ready;
  assign hs      = o_valid && o_ready;
  assign pop     = hs && (beat == LAST);

  lane_fifo2 #(.W(LANE_WIDTH + 1)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({i_sync, i_lane}),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head_sync  = head[LANE_WIDTH];
  assign head_beats = head[LANE_WIDTH-1:0];
  // Beat 0 is the top slice of the word.
  assign beat_idx   = LAST - beat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat <= '0;
    end else if (hs) begin
      beat <= (beat == LAST) ? '0 : BW'(beat + 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) o_overflow <= 1'b0;
    else if (i_valid && !i_ready) o_overflow <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // SEND tracks count > 0; it drops only when the last beat of the sole
  // entry leaves and nothing arrives in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (push) state_nxt = SEND;
      SEND:    if (pop && fifo_count == 2'd1 && !push) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are zero outside SEND so nothing stale leaks during reset/idle.
  always_comb begin
    o_valid = 1'b0;
    o_data  = '0;
    o_sop   = 1'b0;
    o_eow   = 1'b0;
    if (state == SEND) begin
      o_valid = 1'b1;
      o_data  = head_beats[beat_idx];
      o_sop   = head_sync && (beat == '0);
      o_eow   = (beat == LAST);
    end
  end

endmodule

// File: tb/tb_lane_gearbox.sv
module tb_lane_gearbox;

  localparam int LW = 1360;
  localparam int OW = 136;
  localparam int NB = LW / OW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_valid = 1'b0;
  logic [LW-1:0] i_lane = '0;
  logic          i_sync = 1'b0;
  logic          i_ready;
  logic          o_valid;
  logic          o_ready = 1'b0;
  logic [OW-1:0] o_data;
  logic          o_sop;
  logic          o_eow;
  logic          o_overflow;

  lane_gearbox #(.LANE_WIDTH(LW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_lane(i_lane), .i_sync(i_sync),
    .i_ready(i_ready), .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
    .o_sop(o_sop), .o_eow(o_eow), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of accepted words, beat position of the head word.
  typedef struct { logic [LW-1:0] w; logic s; } ent_t;
  typedef struct { logic [OW-1:0] d; logic s; logic e; } beat_t;
  ent_t  mq[$];
  int    mbeat = 0;
  bit    movf = 0;
  beat_t got[$];

  function automatic logic [OW-1:0] slice(input logic [LW-1:0] w, input int k);
    return w[LW-1-k*OW -: OW];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      mbeat = 0;
      movf  = 0;
    end else begin
      bit acc;
      ent_t e;
      acc = i_valid && (mq.size() < 2);
      if (i_valid && !acc) movf = 1;
      if (mq.size() > 0 && o_ready) begin
        if (mbeat == NB-1) begin
          void'(mq.pop_front());
          mbeat = 0;
        end else mbeat++;
      end
      if (acc) begin
        e.w = i_lane; e.s = i_sync;
        mq.push_back(e);
      end
    end
  end

  // Per-cycle compare; inputs change just after posedge so the o_ready seen
  // here is the one the next edge samples.
  always @(negedge clk) begin
    bit ev;
    beat_t b;
    ev = (mq.size() > 0);
    chk("o_valid", o_valid, ev);
    chk("i_ready", i_ready, mq.size() < 2);
    chk("o_overflow", o_overflow, movf);
    if (ev) begin
      chk("o_data", o_data, slice(mq[0].w, mbeat));
      chk("o_sop", o_sop, mq[0].s && mbeat == 0);
      chk("o_eow", o_eow, mbeat == NB-1);
    end else if (!rst) begin
      chk("rst_o_data", o_data, '0);
      chk("rst_o_sop", o_sop, 1'b0);
      chk("rst_o_eow", o_eow, 1'b0);
    end
    if (o_valid && o_ready) begin
      b.d = o_data; b.s = o_sop; b.e = o_eow;
      got.push_back(b);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_beats(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (got.size() >= n) break;
      tick();
    end
    chk("beat_timeout", got.size() >= n, 1'b1);
  endtask

  function automatic logic [LW-1:0] rand_word();
    logic [LW-1:0] w;
    w = '0;
    for (int j = 0; j < LW/32 + 1; j++) w = (w << 32) | LW'($urandom);
    return w;
  endfunction

  logic [LW-1:0] ramp;
  logic [LW-1:0] wa, wb;
  int vcnt;

  initial begin
    for (int k = 0; k < NB; k++) ramp[LW-1-k*OW -: OW] = OW'(k);

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_o_valid", o_valid, 1'b0);
    chk("reset_i_ready", i_ready, 1'b1);
    chk("reset_o_overflow", o_overflow, 1'b0);
    chk("reset_o_data", o_data, '0);
    tick();
    rst = 1'b1;
    tick();

    // Single word, beat k carries k
    o_ready = 1'b1;
    got.delete();
    i_valid = 1'b1; i_lane = ramp; i_sync = 1'b1;
    tick();
    i_valid = 1'b0;
    chk("latency_o_valid", o_valid, 1'b1);
    chk("first_sop", o_sop, 1'b1);
    wait_beats(NB, 20);
    repeat (2) tick();
    chk("single_done_valid", o_valid, 1'b0);
    chk("single_count", got.size(), NB);
    for (int k = 0; k < NB && k < got.size(); k++) begin
      chk("single_data", got[k].d, OW'(k));
      chk("single_sop", got[k].s, k == 0);
      chk("single_eow", got[k].e, k == NB-1);
    end

    // Stall at beat 4 for three cycles
    got.delete();
    i_valid = 1'b1; i_lane = ramp; i_sync = 1'b0;
    tick();
    i_valid = 1'b0;
    repeat (4) tick();
    o_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("stall_hold_data", o_data, OW'(4));
      chk("stall_hold_valid", o_valid, 1'b1);
      if (c < 3) tick();
    end
    o_ready = 1'b1;
    wait_beats(NB, 20);
    chk("stall_count", got.size(), NB);
    for (int k = 0; k < NB && k < got.size(); k++) chk("stall_order", got[k].d, OW'(k));
    repeat (3) tick();

    // Back-to-back words, one every NB cycles
    got.delete();
    vcnt = 0;
    for (int n = 0; n < 4; n++) begin
      i_valid = 1'b1; i_lane = rand_word(); i_sync = n[0];
      tick();
      vcnt += int'(o_valid);
      i_valid = 1'b0;
      for (int c = 0; c < NB-1; c++) begin
        tick();
        vcnt += int'(o_valid);
      end
    end
    chk("b2b_no_bubble", vcnt, 4*NB);
    wait_beats(4*NB, 10);
    repeat (3) tick();

    // Overflow: three pushes with egress blocked
    got.delete();
    o_ready = 1'b0;
    wa = rand_word(); wb = rand_word();
    i_valid = 1'b1; i_lane = wa; i_sync = 1'b1;
    tick();
    i_lane = wb; i_sync = 1'b0;
    tick();
    chk("ovf_i_ready_low", i_ready, 1'b0);
    i_lane = rand_word();
    tick();
    i_valid = 1'b0;
    chk("ovf_set", o_overflow, 1'b1);
    repeat (3) tick();
    chk("ovf_held", o_overflow, 1'b1);
    o_ready = 1'b1;
    wait_beats(2*NB, 30);
    for (int k = 0; k < 2*NB && k < got.size(); k++)
      chk("ovf_words_intact", got[k].d, (k < NB) ? slice(wa, k) : slice(wb, k-NB));
    repeat (3) tick();
    chk("ovf_sticky", o_overflow, 1'b1);

    // Reset pulse at beat 5
    got.delete();
    i_valid = 1'b1; i_lane = ramp; i_sync = 1'b1;
    tick();
    i_valid = 1'b0;
    repeat (5) tick();
    chk("pre_rst_beat5", o_data, OW'(5));
    rst = 1'b0;
    #1;
    chk("rst_valid_zero", o_valid, 1'b0);
    chk("rst_data_zero", o_data, '0);
    chk("rst_ovf_cleared", o_overflow, 1'b0);
    repeat (2) tick();
    chk("rst_i_ready", i_ready, 1'b1);
    rst = 1'b1;
    repeat (5) tick();
    chk("no_residual_valid", o_valid, 1'b0);
    chk("no_residual_beats", got.size(), 5);
    i_valid = 1'b1; i_lane = ramp; i_sync = 1'b1;
    tick();
    i_valid = 1'b0;
    chk("post_rst_sop", o_sop, 1'b1);
    chk("post_rst_beat0", o_data, OW'(0));
    tick();
    chk("post_rst_beat1", o_data, OW'(1));
    repeat (12) tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      i_valid = ($urandom_range(0, 2) == 0);
      i_sync  = $urandom_range(0, 1) == 1;
      i_lane  = i_valid ? rand_word() : i_lane;
      o_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    repeat (30) tick();
    chk("drain_idle", o_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
